// File: rtl/code_store_bank_pkg.sv
// Shared definitions for the code store bank: FSM state encoding, default
// geometry and the code-width helper shared with the comparator.
package code_store_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRST   = 2'd1,
    ST_CONFIRM = 2'd2
  } state_e;

  localparam int DEF_DIGITS  = 4;
  localparam int DEF_DIGIT_W = 4;
  localparam int DEF_SLOTS   = 4;
  localparam int DEF_SLOT_W  = 2;
  localparam int DEF_ROT     = 1;
  localparam int DEF_TIMEOUT = 1024;

  function automatic int code_width(int digits, int digit_w);
    return digits * digit_w;
  endfunction

endpackage

// File: rtl/code_store_bank_if.sv
// Enrolment, clear and read-port signals between the keypad/comparator side
// (master) and the code store bank (slave).
interface code_store_bank_if #(
  parameter int CODE_W = code_store_bank_pkg::code_width(code_store_bank_pkg::DEF_DIGITS,
                                                         code_store_bank_pkg::DEF_DIGIT_W),
  parameter int SLOT_W = code_store_bank_pkg::DEF_SLOT_W,
  parameter int SLOTS  = code_store_bank_pkg::DEF_SLOTS
);
  logic              enroll_start;
  logic [SLOT_W-1:0] slot_sel;
  logic [CODE_W-1:0] code_in;
  logic              code_strobe;
  logic              clear_slot;
  logic [SLOT_W-1:0] rd_slot;
  logic [CODE_W-1:0] rd_code;
  logic              rd_valid;
  logic [SLOTS-1:0]  valid_mask;
  logic              busy;
  logic              done;
  logic              err_mismatch;
  logic              err_range;
  logic              err_timeout;

  modport master (
    output enroll_start, slot_sel, code_in, code_strobe, clear_slot, rd_slot,
    input  rd_code, rd_valid, valid_mask, busy, done, err_mismatch, err_range, err_timeout
  );

  modport slave (
    input  enroll_start, slot_sel, code_in, code_strobe, clear_slot, rd_slot,
    output rd_code, rd_valid, valid_mask, busy, done, err_mismatch, err_range, err_timeout
  );
endinterface

// File: rtl/code_scrambler.sv
// Combinational plain-to-stored mapping: digit i moves to digit (i+ROT) mod DIGITS.
// Also used by the comparator to scramble candidate codes.
module code_scrambler
  import code_store_bank_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int ROT     = DEF_ROT
) (
  input  logic [DIGITS*DIGIT_W-1:0] code_i,
  output logic [DIGITS*DIGIT_W-1:0] code_o
);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign code_o[((i + ROT) % DIGITS)*DIGIT_W +: DIGIT_W] = code_i[i*DIGIT_W +: DIGIT_W];
  end

endmodule

// File: rtl/code_store_bank.sv
// Bank of SLOTS scrambled code slots committed through an enrol-and-confirm FSM.
// Define ENROLL_TIMEOUT_EN to abort enrolment after TIMEOUT_CYCLES idle cycles.
module code_store_bank
  import code_store_bank_pkg::*;
#(
  parameter int DIGITS         = DEF_DIGITS,
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int SLOTS          = DEF_SLOTS,
  parameter int SLOT_W         = DEF_SLOT_W,
  parameter int SCRAMBLE_ROT   = DEF_ROT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  code_store_bank_if.slave  bus
);

  localparam int CODE_W = code_width(DIGITS, DIGIT_W);

  if ((2 ** SLOT_W) < SLOTS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("code_store_bank: SLOT_W too narrow for SLOTS or TIMEOUT_CYCLES < 1");
  end

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CODE_W-1:0] first_q, first_d;
  logic [CODE_W-1:0] code_q [SLOTS];
  logic [SLOTS-1:0]  valid_q;
  logic [CODE_W-1:0] rd_code_q;
  logic              rd_valid_q;
  logic              done_q, done_d;
  logic              err_mm_q, err_mm_d;
  logic              err_rng_q, err_rng_d;
  logic              wr_en, clr_en;
  logic              sel_ok, rd_ok;
  logic [CODE_W-1:0] scr_code;

  assign sel_ok = (int'(bus.slot_sel) < SLOTS);
  assign rd_ok  = (int'(bus.rd_slot) < SLOTS);

  code_scrambler #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .ROT     (SCRAMBLE_ROT)
  ) u_scrambler (
    .code_i (bus.code_in),
    .code_o (scr_code)
  );

`ifdef ENROLL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;
  logic             err_to_q, err_to_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restart on entry to FIRST and on every serviced strobe; idle holds zero.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_q == ST_IDLE || state_d == ST_IDLE || bus.code_strobe) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign bus.err_timeout = err_to_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    first_d   = first_q;
    done_d    = 1'b0;
    err_mm_d  = 1'b0;
    err_rng_d = 1'b0;
    wr_en     = 1'b0;
    clr_en    = 1'b0;
`ifdef ENROLL_TIMEOUT_EN
    err_to_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enroll_start) begin
          if (sel_ok) begin
            slot_d  = bus.slot_sel;
            state_d = ST_FIRST;
          end else begin
            err_rng_d = 1'b1;
          end
        end else if (bus.clear_slot) begin
          if (sel_ok) clr_en = 1'b1;
          else        err_rng_d = 1'b1;
        end
      end
      ST_FIRST: begin
        if (bus.code_strobe) begin
          first_d = bus.code_in;
          state_d = ST_CONFIRM;
        end
`ifdef ENROLL_TIMEOUT_EN
        else if (expired) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      ST_CONFIRM: begin
        if (bus.code_strobe) begin
          state_d = ST_IDLE;
          if (bus.code_in == first_q) begin
            wr_en  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_mm_d = 1'b1;
          end
        end
`ifdef ENROLL_TIMEOUT_EN
        else if (expired) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read samples pre-edge contents, so a same-edge write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      first_q    <= '0;
      valid_q    <= '0;
      for (int i = 0; i < SLOTS; i++) code_q[i] <= '0;
      rd_code_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_mm_q   <= 1'b0;
      err_rng_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      first_q    <= first_d;
      rd_code_q  <= rd_ok ? code_q[bus.rd_slot] : '0;
      rd_valid_q <= rd_ok & valid_q[bus.rd_slot];
      done_q     <= done_d;
      err_mm_q   <= err_mm_d;
      err_rng_q  <= err_rng_d;
      if (wr_en) begin
        code_q[slot_q]  <= scr_code;
        valid_q[slot_q] <= 1'b1;
      end
      if (clr_en) begin
        code_q[bus.slot_sel]  <= '0;
        valid_q[bus.slot_sel] <= 1'b0;
      end
    end
  end

  assign bus.rd_code      = rd_code_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.valid_mask   = valid_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.err_mismatch = err_mm_q;
  assign bus.err_range    = err_rng_q;

endmodule
